// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: boot delay, trap/jump redirects,
// fetch handshake with pipeline hold, +2/+4 stepping and debug halt/resume.
module pc_gen #(
  parameter int unsigned              InstAddrBus      = 32,
  parameter int unsigned              HoldFlagBus      = 3,
  parameter int unsigned              HoldThreshold    = 1,
  parameter logic [InstAddrBus-1:0]   ResetAddr        = '0,
  parameter int unsigned              BootDelay        = 4,
  parameter bit                       EnableCompressed = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_jtag_reset_flag,
  input  logic                   i_trap_flag,
  input  logic [InstAddrBus-1:0] i_trap_addr,
  input  logic                   i_jump_flag,
  input  logic [InstAddrBus-1:0] i_jump_addr,
  input  logic [HoldFlagBus-1:0] i_hold_flag,
  input  logic                   i_fetch_ready,
  input  logic                   i_inst_is_c,
  input  logic                   i_halt_req,
  input  logic                   i_resume_req,
  input  logic                   i_resume_addr_vld,
  input  logic [InstAddrBus-1:0] i_resume_addr,
  output logic [InstAddrBus-1:0] o_pc,
  output logic                   o_pc_valid,
  output logic                   o_halted,
  output logic                   o_redirect
);

  localparam int unsigned CntW = (BootDelay == 0) ? 1 : $clog2(BootDelay + 1);
  localparam logic [CntW-1:0] BOOT_LAST = CntW'(BootDelay);
  localparam logic [InstAddrBus-1:0] ALIGN_MASK =
    EnableCompressed ? ~InstAddrBus'(1) : ~InstAddrBus'(3);
  localparam logic [InstAddrBus-1:0] STEP_C = InstAddrBus'(2);
  localparam logic [InstAddrBus-1:0] STEP_F = InstAddrBus'(4);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic                   redirect_q, redirect_d;
  logic                   valid_q, halted_q;
  logic                   stall;
  logic [InstAddrBus-1:0] step;

  assign stall = (32'(i_hold_flag) >= HoldThreshold) || !i_fetch_ready;
  assign step  = (EnableCompressed && i_inst_is_c) ? STEP_C : STEP_F;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (i_jtag_reset_flag) begin
      state_d    = S_BOOT;
      cnt_d      = '0;
      pc_d       = ResetAddr;
      redirect_d = 1'b1;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          if (cnt_q == BOOT_LAST) state_d = S_RUN;
          else                    cnt_d   = cnt_q + CntW'(1);
        end
        S_RUN: begin
          // Redirects still land when halting; only the sequential step is dropped.
          if (i_trap_flag) begin
            pc_d       = i_trap_addr & ALIGN_MASK;
            redirect_d = 1'b1;
          end else if (i_jump_flag) begin
            pc_d       = i_jump_addr & ALIGN_MASK;
            redirect_d = 1'b1;
          end else if (!i_halt_req && !stall) begin
            pc_d = pc_q + step;
          end
          if (i_halt_req) state_d = S_HALT;
        end
        S_HALT: begin
          if (i_resume_req) begin
            state_d = S_RUN;
            if (i_resume_addr_vld) begin
              pc_d       = i_resume_addr & ALIGN_MASK;
              redirect_d = 1'b1;
            end
          end
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_BOOT;
      cnt_q      <= '0;
      pc_q       <= ResetAddr;
      redirect_q <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      valid_q    <= (state_d == S_RUN);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign o_pc       = pc_q;
  assign o_pc_valid = valid_q;
  assign o_halted   = halted_q;
  assign o_redirect = redirect_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: instance A (compressed, BootDelay=4, ResetAddr=8000_0000)
// and instance B (4-byte only, BootDelay=0) share all stimulus.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic        redir;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jtag, trap, jump, fetch_ready, is_c, halt_req, resume_req, resume_vld;
  logic [31:0] trap_addr, jump_addr, resume_addr;
  logic [2:0]  hold;
  logic [31:0] pc_a, pc_b;
  logic        valid_a, halted_a, redir_a, valid_b, halted_b, redir_b;

  obs_t exp_q[$];
  obs_t expb_q[$];
  obs_t e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .InstAddrBus(32), .HoldFlagBus(3), .HoldThreshold(1),
    .ResetAddr(32'h8000_0000), .BootDelay(4), .EnableCompressed(1'b1)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_jtag_reset_flag(jtag),
    .i_trap_flag(trap), .i_trap_addr(trap_addr),
    .i_jump_flag(jump), .i_jump_addr(jump_addr),
    .i_hold_flag(hold), .i_fetch_ready(fetch_ready), .i_inst_is_c(is_c),
    .i_halt_req(halt_req), .i_resume_req(resume_req),
    .i_resume_addr_vld(resume_vld), .i_resume_addr(resume_addr),
    .o_pc(pc_a), .o_pc_valid(valid_a), .o_halted(halted_a), .o_redirect(redir_a)
  );

  pc_gen #(
    .InstAddrBus(32), .HoldFlagBus(3), .HoldThreshold(1),
    .ResetAddr(32'h0000_0000), .BootDelay(0), .EnableCompressed(1'b0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_jtag_reset_flag(jtag),
    .i_trap_flag(trap), .i_trap_addr(trap_addr),
    .i_jump_flag(jump), .i_jump_addr(jump_addr),
    .i_hold_flag(hold), .i_fetch_ready(fetch_ready), .i_inst_is_c(is_c),
    .i_halt_req(halt_req), .i_resume_req(resume_req),
    .i_resume_addr_vld(resume_vld), .i_resume_addr(resume_addr),
    .o_pc(pc_b), .o_pc_valid(valid_b), .o_halted(halted_b), .o_redirect(redir_b)
  );

  function automatic obs_t obs_a();
    return '{pc_a, valid_a, halted_a, redir_a};
  endfunction

  function automatic obs_t obs_b();
    return '{pc_b, valid_b, halted_b, redir_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_q.push_back('{32'h8000_0000, 1'b0, 1'b0, 1'b0});
    expb_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0});
    #2;
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL reset_a got=%h exp=%h", obs_a(), e); end
    e = expb_q.pop_front(); checks++;
    if (obs_b() !== e) begin failures++; $display("FAIL reset_b got=%h exp=%h", obs_b(), e); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_boot();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{32'h8000_0000, 1'b0, 1'b0, 1'b0});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs_a() !== e) begin failures++; $display("FAIL boot_wait%0d got=%h exp=%h", i, obs_a(), e); end
    end
    exp_q.push_back('{32'h8000_0000, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{32'h8000_0004, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{32'h8000_0008, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs_a() !== e) begin failures++; $display("FAIL boot_run%0d got=%h exp=%h", i, obs_a(), e); end
    end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_addr = 32'hFFFF_FFFE;
    exp_q.push_back('{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL wrap_load got=%h exp=%h", obs_a(), e); end
    jump = 1'b0; is_c = 1'b1;
    exp_q.push_back('{32'h0, 1'b1, 1'b0, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL wrap_step got=%h exp=%h", obs_a(), e); end
    is_c = 1'b0;
    exp_q.push_back('{32'h4, 1'b1, 1'b0, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL wrap_after got=%h exp=%h", obs_a(), e); end
  endtask

  task automatic test_priority();
    trap = 1'b1; trap_addr = 32'h100; jump = 1'b1; jump_addr = 32'h200; hold = 3'b111;
    exp_q.push_back('{32'h100, 1'b1, 1'b0, 1'b1});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL prio_trap got=%h exp=%h", obs_a(), e); end
    trap = 1'b0; jump = 1'b0; hold = '0;
    exp_q.push_back('{32'h104, 1'b1, 1'b0, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL prio_after got=%h exp=%h", obs_a(), e); end
  endtask

  task automatic test_align_nocomp();
    jump = 1'b1; jump_addr = 32'h203; is_c = 1'b1;
    exp_q.push_back('{32'h202, 1'b1, 1'b0, 1'b1});
    expb_q.push_back('{32'h200, 1'b1, 1'b0, 1'b1});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL align_c got=%h exp=%h", obs_a(), e); end
    e = expb_q.pop_front(); checks++;
    if (obs_b() !== e) begin failures++; $display("FAIL align_noc got=%h exp=%h", obs_b(), e); end
    jump = 1'b0;
    exp_q.push_back('{32'h204, 1'b1, 1'b0, 1'b0});
    expb_q.push_back('{32'h204, 1'b1, 1'b0, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL step_c got=%h exp=%h", obs_a(), e); end
    e = expb_q.pop_front(); checks++;
    if (obs_b() !== e) begin failures++; $display("FAIL step_noc got=%h exp=%h", obs_b(), e); end
    is_c = 1'b0;
  endtask

  task automatic test_stall();
    fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin fetch_ready = 1'b1; hold = 3'd1; end
      exp_q.push_back('{32'h204, 1'b1, 1'b0, 1'b0});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs_a() !== e) begin failures++; $display("FAIL stall%0d got=%h exp=%h", i, obs_a(), e); end
    end
    hold = '0;
    exp_q.push_back('{32'h208, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{32'h20C, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs_a() !== e) begin failures++; $display("FAIL unstall%0d got=%h exp=%h", i, obs_a(), e); end
    end
  endtask

  task automatic test_halt_resume();
    halt_req = 1'b1; jump = 1'b1; jump_addr = 32'h400;
    exp_q.push_back('{32'h400, 1'b0, 1'b1, 1'b1});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL halt_jump got=%h exp=%h", obs_a(), e); end
    halt_req = 1'b0; jump_addr = 32'h600; trap = 1'b1; trap_addr = 32'h640;
    exp_q.push_back('{32'h400, 1'b0, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL halt_ignore got=%h exp=%h", obs_a(), e); end
    jump = 1'b0; trap = 1'b0; resume_req = 1'b1; resume_vld = 1'b1; resume_addr = 32'h500;
    exp_q.push_back('{32'h500, 1'b1, 1'b0, 1'b1});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL resume_addr got=%h exp=%h", obs_a(), e); end
    resume_req = 1'b0; resume_vld = 1'b0;
    exp_q.push_back('{32'h504, 1'b1, 1'b0, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL resume_step got=%h exp=%h", obs_a(), e); end
    halt_req = 1'b1;
    exp_q.push_back('{32'h504, 1'b0, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL halt_nostep got=%h exp=%h", obs_a(), e); end
    halt_req = 1'b0; resume_req = 1'b1; resume_addr = 32'h700;
    exp_q.push_back('{32'h504, 1'b1, 1'b0, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL resume_noaddr got=%h exp=%h", obs_a(), e); end
    resume_req = 1'b0;
    exp_q.push_back('{32'h508, 1'b1, 1'b0, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL resume_run got=%h exp=%h", obs_a(), e); end
  endtask

  task automatic test_jtag_in_halt();
    halt_req = 1'b1;
    exp_q.push_back('{32'h508, 1'b0, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL jtag_prehalt got=%h exp=%h", obs_a(), e); end
    halt_req = 1'b0; jtag = 1'b1; resume_req = 1'b1; resume_vld = 1'b1; resume_addr = 32'h700;
    exp_q.push_back('{32'h8000_0000, 1'b0, 1'b0, 1'b1});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL jtag_reset got=%h exp=%h", obs_a(), e); end
    jtag = 1'b0; resume_req = 1'b0; resume_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      jump = (i == 1 || i == 2); jump_addr = 32'h900;
      trap = (i == 1); trap_addr = 32'h980; halt_req = (i == 2);
      exp_q.push_back('{32'h8000_0000, 1'b0, 1'b0, 1'b0});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs_a() !== e) begin failures++; $display("FAIL jtag_boot%0d got=%h exp=%h", i, obs_a(), e); end
    end
    jump = 1'b0; trap = 1'b0; halt_req = 1'b0;
    exp_q.push_back('{32'h8000_0000, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{32'h8000_0004, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs_a() !== e) begin failures++; $display("FAIL jtag_run%0d got=%h exp=%h", i, obs_a(), e); end
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    exp_q.push_back('{32'h8000_0000, 1'b0, 1'b0, 1'b0});
    expb_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL async_a got=%h exp=%h", obs_a(), e); end
    e = expb_q.pop_front(); checks++;
    if (obs_b() !== e) begin failures++; $display("FAIL async_b got=%h exp=%h", obs_b(), e); end
    tick();
    rst_n = 1'b1;
    exp_q.push_back('{32'h8000_0000, 1'b0, 1'b0, 1'b0});
    expb_q.push_back('{32'h0, 1'b1, 1'b0, 1'b0});
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_a() !== e) begin failures++; $display("FAIL rearm_a got=%h exp=%h", obs_a(), e); end
    e = expb_q.pop_front(); checks++;
    if (obs_b() !== e) begin failures++; $display("FAIL boot0_b got=%h exp=%h", obs_b(), e); end
  endtask

  initial begin
    rst_n = 1'b1;
    jtag = 1'b0; trap = 1'b0; jump = 1'b0; halt_req = 1'b0;
    resume_req = 1'b0; resume_vld = 1'b0; fetch_ready = 1'b1; is_c = 1'b0;
    trap_addr = '0; jump_addr = '0; resume_addr = '0; hold = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_boot();
    test_wrap();
    test_priority();
    test_align_nocomp();
    test_stall();
    test_halt_resume();
    test_jtag_in_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the core fetch stage, successor to the fixed single-width PC register. It produces the fetch address from several sources:
- a configurable reset vector and a post-reset boot delay
- trap and jump redirects with fixed priority
- a fetch valid/ready handshake and pipeline hold
- compressed (+2) or full (+4) sequential increment
- a debug halt/resume state machine

It sits between the control/exception unit and the instruction fetch interface.

## Interface
- InstAddrBus, 32, PC width in bits (≥ 8)
- HoldFlagBus, 3, width of pipeline hold level
- HoldThreshold, 1, PC stalls when i_hold_flag ≥ this value (unsigned)
- ResetAddr, 32'h0000_0000, PC value after reset / JTAG reset (truncated to InstAddrBus)
- BootDelay, 4, cycles spent in BOOT before first valid fetch (0 allowed)
- EnableCompressed, 1, 1 = 2-byte alignment and +2 steps allowed; 0 = 4-byte only
- Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_jtag_reset_flag  in  1  synchronous soft reset
- i_trap_flag  in  1  trap redirect request
- i_trap_addr  in  InstAddrBus  trap target
- i_jump_flag  in  1  jump/branch redirect request
- i_jump_addr  in  InstAddrBus  jump target
- i_hold_flag  in  HoldFlagBus  pipeline pause level
- i_fetch_ready  in  1  fetch unit accepts o_pc this cycle
- i_inst_is_c  in  1  instruction at o_pc is 16-bit (ignored if EnableCompressed=0)
- i_halt_req  in  1  debug halt request
- i_resume_req  in  1  debug resume request
- i_resume_addr_vld  in  1  i_resume_addr is valid with the resume request
- i_resume_addr  in  InstAddrBus  resume target
- o_pc  out  InstAddrBus  current fetch address
- o_pc_valid  out  1  o_pc is a valid fetch request
- o_halted  out  1  core in debug halt
- o_redirect  out  1  o_pc was loaded by trap/jump/resume/reset in the previous cycle

## Operation
- States: BOOT, RUN, HALT.
- Reset values: state BOOT, o_pc=ResetAddr, o_pc_valid=0, o_halted=0, o_redirect=0, boot counter=0.
- BOOT:
  - o_pc_valid=0; counter increments each cycle.
  - Enter RUN on the clock where the counter reaches BootDelay. BootDelay=0 means RUN on the first clock after reset release.
  - Trap, jump, halt and hold are ignored in BOOT.
- RUN: o_pc_valid=1. Per-clock priority, first match wins:
  1. i_jtag_reset_flag: o_pc←ResetAddr, state←BOOT, counter←0.
  2. i_trap_flag: o_pc←aligned(i_trap_addr).
  3. i_jump_flag: o_pc←aligned(i_jump_addr).
  4. i_hold_flag ≥ HoldThreshold, or i_fetch_ready=0: o_pc unchanged.
  5. Otherwise: o_pc←o_pc + (EnableCompressed && i_inst_is_c ? 2 : 4), modulo 2^InstAddrBus (wraps silently).
- Halt in RUN:
  - If i_halt_req=1 and no jtag reset, state←HALT after this cycle's o_pc update. A redirect in the same cycle is applied before halting.
  - In that case the sequential step (rule 5) is suppressed.
- HALT:
  - o_pc_valid=0, o_halted=1; o_pc frozen. Trap, jump and hold are ignored.
  - i_resume_req: state←RUN; if i_resume_addr_vld, o_pc←aligned(i_resume_addr).
  - i_jtag_reset_flag overrides resume.
- aligned(): clears bit 0; additionally clears bit 1 when EnableCompressed=0.
- o_redirect is registered: 1 for exactly the cycle after a trap, jump, address-carrying resume or jtag reset load, else 0.
- o_halted is registered from the state: 1 exactly while in HALT.
- Asserting i_rst_n low at any point immediately forces all reset values, independent of the clock.

## Timing
- All outputs are registered; no combinational input→output paths.
- Redirect latency: target appears on o_pc one clock after the flag is sampled.
- First valid fetch: o_pc_valid rises BootDelay+1 clocks after the first rising edge with i_rst_n=1. For BootDelay=0 this is 1 clock.
- Handshake: a fetch transfers on an edge with o_pc_valid && i_fetch_ready. o_pc holds stable while o_pc_valid=1 and i_fetch_ready=0, unless a redirect occurs.
- Halt takes effect the clock after i_halt_req. Resume gives o_pc_valid=1 the clock after i_resume_req.

## Test plan
- Reset and boot: ResetAddr=32'h8000_0000, BootDelay=4. Release reset → o_pc_valid low for 4 clocks, then high with o_pc=32'h8000_0000. With i_fetch_ready=1 and i_inst_is_c=0, the following clocks give 8000_0004, 8000_0008.
- Compressed step and wrap: o_pc=32'hFFFF_FFFE, i_inst_is_c=1 → o_pc=0. With EnableCompressed=0, i_inst_is_c=1 still steps +4.
- Priority: trap (addr 0x100), jump (addr 0x200) and hold=3'b111 in the same cycle → o_pc=0x100, o_redirect=1 next cycle. Jump alone to 0x203 → o_pc=0x202 (EnableCompressed=1) or 0x200 (EnableCompressed=0).
- Stall: i_fetch_ready=0 for 3 clocks, then i_hold_flag=1 for 2 clocks → o_pc constant, o_pc_valid=1. Then stepping resumes with +4.
- Halt/resume: i_halt_req together with jump to 0x400 → o_pc=0x400, o_halted=1, o_pc_valid=0. A jump while halted is ignored. Resume with addr 0x500 → o_pc=0x500, o_pc_valid=1, o_redirect=1.
- Resets mid-operation:
  - i_jtag_reset_flag in HALT → BOOT, o_pc=ResetAddr, BootDelay replayed.
  - Async i_rst_n pulse between edges → outputs reset immediately.
